// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types for the unified instruction/data memory arbiter.
// The latched request is a fixed RV32-width record; the top casts it to its port widths.
package unified_mem_arbiter_pkg;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  localparam int ARB_AW = 32;
  localparam int ARB_DW = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } arb_owner_e;

  typedef struct packed {
    logic [ARB_AW-1:0] addr;
    logic [ARB_DW-1:0] wdata;
    logic              we;
    logic [2:0]        funct3;
    arb_owner_e        owner;
  } arb_req_t;

endpackage

// File: rtl/unified_mem_arbiter_select.sv
// Winner selection between fetch and data requesters, with a saturating
// starvation counter that forces a fetch grant after STARVE_MAX data wins.
module mem_arb_select
  import unified_mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       if_req_i,
  input  logic       d_req_i,
  input  logic       fire_i,
  output arb_owner_e win_o
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] starve_cnt_q;
  logic [CW-1:0] starve_cnt_d;
  logic          force_if;

  assign force_if = if_req_i && d_req_i && (starve_cnt_q == CW'(STARVE_MAX));
  assign win_o    = (d_req_i && !force_if) ? OWN_D : OWN_IF;

  // Only D wins that leave a fetch waiting count toward starvation.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (fire_i) begin
      if (win_o == OWN_D && if_req_i) begin
        if (starve_cnt_q != CW'(STARVE_MAX)) begin
          starve_cnt_d = starve_cnt_q + CW'(1);
        end
      end else begin
        starve_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates the single unified memory between instruction fetch and load/store,
// sequencing each access through IDLE -> BUSY (MEM_LATENCY cycles) -> RESP.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int AWIDTH      = 32,
  parameter int DWIDTH      = 32,
  parameter int MEM_LATENCY = 1,
  parameter int STARVE_MAX  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [AWIDTH-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DWIDTH-1:0] if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [AWIDTH-1:0] d_addr_i,
  input  logic [DWIDTH-1:0] d_wdata_i,
  input  logic [2:0]        d_funct3_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [DWIDTH-1:0] d_rdata_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_data_o,
  output logic              mem_read_en_o,
  output logic              mem_write_en_o,
  output logic [2:0]        mem_funct3_o,
  input  logic [DWIDTH-1:0] mem_data_i,
  output logic              busy_o
);

  // Handshake: req is a level held with its fields until a one-cycle gnt pulse;
  // requests are only sampled in IDLE, and one rvalid pulse closes each grant.

  localparam int LW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  arb_state_e        state_q;
  logic [LW-1:0]     lat_cnt_q;
  arb_req_t          req_q;
  arb_req_t          req_d;
  arb_owner_e        win;
  logic              fire;
  logic              if_gnt_q;
  logic              d_gnt_q;
  logic              if_rvalid_q;
  logic              d_rvalid_q;
  logic              rd_en_q;
  logic              wr_en_q;
  logic [DWIDTH-1:0] if_rdata_q;
  logic [DWIDTH-1:0] d_rdata_q;

  assign fire = (state_q == IDLE) && (if_req_i || d_req_i);

  mem_arb_select #(
    .STARVE_MAX(STARVE_MAX)
  ) u_select (
    .clk     (clk),
    .rst     (rst),
    .if_req_i(if_req_i),
    .d_req_i (d_req_i),
    .fire_i  (fire),
    .win_o   (win)
  );

  // Fetches are always word reads with no write data.
  always_comb begin
    req_d = '0;
    if (win == OWN_D) begin
      req_d.addr   = ARB_AW'(d_addr_i);
      req_d.wdata  = ARB_DW'(d_wdata_i);
      req_d.we     = d_we_i;
      req_d.funct3 = d_funct3_i;
      req_d.owner  = OWN_D;
    end else begin
      req_d.addr   = ARB_AW'(if_addr_i);
      req_d.wdata  = '0;
      req_d.we     = 1'b0;
      req_d.funct3 = FUNCT3_LW;
      req_d.owner  = OWN_IF;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      lat_cnt_q   <= '0;
      req_q       <= '0;
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if_rvalid_q <= 1'b0;
          d_rvalid_q  <= 1'b0;
          if (fire) begin
            state_q   <= BUSY;
            lat_cnt_q <= LW'(MEM_LATENCY - 1);
            req_q     <= req_d;
            if_gnt_q  <= (req_d.owner == OWN_IF);
            d_gnt_q   <= (req_d.owner == OWN_D);
            rd_en_q   <= !req_d.we;
            wr_en_q   <= req_d.we;
          end
        end
        BUSY: begin
          if_gnt_q <= 1'b0;
          d_gnt_q  <= 1'b0;
          wr_en_q  <= 1'b0;
          if (lat_cnt_q == '0) begin
            state_q <= RESP;
            rd_en_q <= 1'b0;
            if (!req_q.we) begin
              if (req_q.owner == OWN_IF) begin
                if_rdata_q <= mem_data_i;
              end else begin
                d_rdata_q <= mem_data_i;
              end
            end
            if_rvalid_q <= (req_q.owner == OWN_IF);
            d_rvalid_q  <= (req_q.owner == OWN_D);
          end else begin
            lat_cnt_q <= lat_cnt_q - LW'(1);
          end
        end
        RESP: begin
          if_rvalid_q <= 1'b0;
          d_rvalid_q  <= 1'b0;
          state_q     <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign if_gnt_o       = if_gnt_q;
  assign d_gnt_o        = d_gnt_q;
  assign if_rvalid_o    = if_rvalid_q;
  assign d_rvalid_o     = d_rvalid_q;
  assign if_rdata_o     = if_rdata_q;
  assign d_rdata_o      = d_rdata_q;
  assign mem_addr_o     = AWIDTH'(req_q.addr);
  assign mem_data_o     = DWIDTH'(req_q.wdata);
  assign mem_funct3_o   = req_q.funct3;
  assign mem_read_en_o  = rd_en_q;
  assign mem_write_en_o = wr_en_q;
  assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: latency-1 instance checked through an event
// scoreboard, plus a latency-3 instance checked against a per-cycle table.
module tb_unified_mem_arbiter;

  localparam int W = 50;
  localparam logic [1:0] K_IFG = 2'd0;
  localparam logic [1:0] K_DG  = 2'd1;
  localparam logic [1:0] K_IFR = 2'd2;
  localparam logic [1:0] K_DR  = 2'd3;
  localparam logic [2:0] F_LW  = 3'b010;
  localparam logic [2:0] F_SW  = 3'b010;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   wr_cnt = 0;
  logic [W-1:0] exp_q[$];

  // latency-1 DUT signals
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
  logic [2:0]  d_funct3 = '0;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_rd_en, mem_wr_en, busy;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_funct3;
  logic [31:0] mem [0:255];

  // latency-3 DUT signals
  logic        d3_req = 1'b0;
  logic [31:0] d3_addr = '0;
  logic        if3_gnt, if3_rvalid, d3_gnt, d3_rvalid, mem3_rd_en, mem3_wr_en, busy3;
  logic [31:0] if3_rdata, d3_rdata, mem3_addr, mem3_wdata, mem3_rdata;
  logic [2:0]  mem3_funct3;
  logic [31:0] mem3 [0:255];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  unified_mem_arbiter #(.AWIDTH(32), .DWIDTH(32), .MEM_LATENCY(1), .STARVE_MAX(4)) u_dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
    .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_funct3_i(d_funct3), .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
    .mem_addr_o(mem_addr), .mem_data_o(mem_wdata), .mem_read_en_o(mem_rd_en),
    .mem_write_en_o(mem_wr_en), .mem_funct3_o(mem_funct3), .mem_data_i(mem_rdata),
    .busy_o(busy)
  );

  unified_mem_arbiter #(.AWIDTH(32), .DWIDTH(32), .MEM_LATENCY(3), .STARVE_MAX(4)) u_dut3 (
    .clk(clk), .rst(rst),
    .if_req_i(1'b0), .if_addr_i(32'h0), .if_gnt_o(if3_gnt),
    .if_rvalid_o(if3_rvalid), .if_rdata_o(if3_rdata),
    .d_req_i(d3_req), .d_we_i(1'b0), .d_addr_i(d3_addr), .d_wdata_i(32'h0),
    .d_funct3_i(F_LW), .d_gnt_o(d3_gnt), .d_rvalid_o(d3_rvalid), .d_rdata_o(d3_rdata),
    .mem_addr_o(mem3_addr), .mem_data_o(mem3_wdata), .mem_read_en_o(mem3_rd_en),
    .mem_write_en_o(mem3_wr_en), .mem_funct3_o(mem3_funct3), .mem_data_i(mem3_rdata),
    .busy_o(busy3)
  );

  // Word memories: combinational read, write on the clock edge.
  assign mem_rdata  = mem[mem_addr[9:2]];
  assign mem3_rdata = mem3[mem3_addr[9:2]];
  always @(posedge clk) if (mem_wr_en) mem[mem_addr[9:2]] <= mem_wdata;
  always @(posedge clk) if (mem3_wr_en) mem3[mem3_addr[9:2]] <= mem3_wdata;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h (cyc %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic logic [W-1:0] ev(input logic [1:0] k, input int c, input logic [31:0] d);
    return {k, 16'(c), d};
  endfunction

  function automatic void pop_cmp(input logic [W-1:0] act);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL ev_unexpected act=%h exp=none", act);
    end else begin
      e = exp_q.pop_front();
      chk("ev", 64'(act), 64'(e));
    end
  endfunction

  // Monitor: every grant/response of the latency-1 DUT must match the queue head.
  always @(negedge clk) begin
    if (mem_wr_en) wr_cnt++;
    if (if_gnt)    pop_cmp(ev(K_IFG, cyc, 32'h0));
    if (d_gnt)     pop_cmp(ev(K_DG,  cyc, 32'h0));
    if (if_rvalid) pop_cmp(ev(K_IFR, cyc, if_rdata));
    if (d_rvalid)  pop_cmp(ev(K_DR,  cyc, d_rdata));
  end

  task automatic do_single(input bit is_d, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [2:0] f3,
                           input logic [31:0] exp_rd);
    int c0;
    c0 = cyc;
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_funct3 = f3;
      exp_q.push_back(ev(K_DG, c0 + 1, 32'h0));
      exp_q.push_back(ev(K_DR, c0 + 2, exp_rd));
    end else begin
      if_req = 1'b1; if_addr = addr;
      exp_q.push_back(ev(K_IFG, c0 + 1, 32'h0));
      exp_q.push_back(ev(K_IFR, c0 + 2, exp_rd));
    end
    @(negedge clk);
    if_req = 1'b0;
    d_req  = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int c0;
    bit is_if;
    logic [4:0] t_rd, t_busy, t_rv, t_gnt;
    for (int i = 0; i < 256; i++) begin
      mem[i]  = 32'h0;
      mem3[i] = 32'h0;
    end
    mem[0]   = 32'h0000_0013;
    mem3[64] = 32'hCAFE_F00D;

    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_gnt", 64'({if_gnt, d_gnt, if_rvalid, d_rvalid}), 64'd0);
    chk("rst_mem_en", 64'({mem_rd_en, mem_wr_en}), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_rdata", 64'({if_rdata, d_rdata}), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // Lone fetch
    do_single(1'b0, 1'b0, 32'h0100_0000, 32'h0, F_LW, 32'h0000_0013);

    // Store then load back; store response leaves d_rdata untouched
    wr_cnt = 0;
    do_single(1'b1, 1'b1, 32'h0100_0100, 32'hDEAD_BEEF, F_SW, 32'h0);
    do_single(1'b1, 1'b0, 32'h0100_0100, 32'h0, F_LW, 32'hDEAD_BEEF);
    chk("wr_en_cycles", 64'(wr_cnt), 64'd1);

    // Simultaneous requests: D first, IF in the next IDLE
    c0 = cyc;
    if_req = 1'b1; if_addr = 32'h0100_0000;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0100_0100; d_funct3 = F_LW;
    exp_q.push_back(ev(K_DG,  c0 + 1, 32'h0));
    exp_q.push_back(ev(K_DR,  c0 + 2, 32'hDEAD_BEEF));
    exp_q.push_back(ev(K_IFG, c0 + 4, 32'h0));
    exp_q.push_back(ev(K_IFR, c0 + 5, 32'h0000_0013));
    @(negedge clk);
    d_req = 1'b0;
    repeat (3) @(negedge clk);
    if_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("q_empty_simul", 64'(exp_q.size()), 64'd0);

    // Starvation: both held; order D,D,D,D,IF,D,D,D,D,IF
    c0 = cyc;
    if_req = 1'b1; d_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      is_if = (k == 4) || (k == 9);
      exp_q.push_back(ev(is_if ? K_IFG : K_DG, c0 + 1 + 3 * k, 32'h0));
      exp_q.push_back(ev(is_if ? K_IFR : K_DR, c0 + 2 + 3 * k,
                         is_if ? 32'h0000_0013 : 32'hDEAD_BEEF));
    end
    repeat (28) @(negedge clk);
    if_req = 1'b0; d_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("q_empty_starve", 64'(exp_q.size()), 64'd0);

    // Latency-3 load on the second instance, cycle by cycle (index 0 = T+1)
    t_gnt  = 5'b00001;
    t_rd   = 5'b00111;
    t_busy = 5'b01111;
    t_rv   = 5'b01000;
    d3_req = 1'b1; d3_addr = 32'h0100_0100;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      d3_req = 1'b0;
      chk("lat3_gnt",   64'(d3_gnt),     64'(t_gnt[k]));
      chk("lat3_rd_en", 64'(mem3_rd_en), 64'(t_rd[k]));
      chk("lat3_busy",  64'(busy3),      64'(t_busy[k]));
      chk("lat3_rv",    64'(d3_rvalid),  64'(t_rv[k]));
      if (k == 3) chk("lat3_rdata", 64'(d3_rdata), 64'h0000_0000_CAFE_F00D);
    end

    // Async reset in the middle of a BUSY cycle
    c0 = cyc;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0100_0100; d_funct3 = F_LW;
    exp_q.push_back(ev(K_DG, c0 + 1, 32'h0));
    @(negedge clk);
    d_req = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_rd_en", 64'(mem_rd_en), 64'd0);
    chk("arst_mem_addr", 64'(mem_addr), 64'd0);
    chk("arst_rdata", 64'({if_rdata, d_rdata}), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_rst_busy", 64'(busy), 64'd0);
    chk("q_empty_final", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
